// File: rtl/pong_pkg.sv
// pong_pkg: FSM state encoding, default screen size and default colours shared by the pong blocks
package pong_pkg;
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_MISS} state_t;
   localparam logic [9:0] H_RES_DEF = 10'd640;
   localparam logic [9:0] V_RES_DEF = 10'd480;
   localparam logic [11:0] WALL_RGB_DEF = 12'hABC;
   localparam logic [11:0] BAR_RGB_DEF = 12'h0F8;
   localparam logic [11:0] BALL_RGB_DEF = 12'h789;
   localparam logic [11:0] BG_RGB_DEF = 12'h6A5;
endpackage

// File: rtl/pong_graphics_anim_if.sv
// pong_graphics_anim_if: pixel stream, buttons in; colour, hit/miss events and miss count out
interface pong_graphics_anim_if;
   logic video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic btn_up;
   logic btn_dn;
   logic btn_serve;
   logic [11:0] rgb_pic;
   logic hit;
   logic miss;
   logic [3:0] miss_cnt;
   modport master (output video_on, pixel_x, pixel_y, btn_up, btn_dn, btn_serve,
                   input rgb_pic, hit, miss, miss_cnt);
   modport slave (input video_on, pixel_x, pixel_y, btn_up, btn_dn, btn_serve,
                  output rgb_pic, hit, miss, miss_cnt);
endinterface

// File: rtl/pong_frame_tick.sv
// pong_frame_tick: clk/reset_n/pixel_x/pixel_y in, refr_tick out; one-clk pulse when the scan enters row V_RES+1, column 0
module pong_frame_tick import pong_pkg::*; #(
   parameter logic [9:0] V_RES = V_RES_DEF
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   output logic       refr_tick
);
   logic ref_now, ref_dly_d, ref_dly_q;
   always_comb begin
      ref_now = (pixel_y == V_RES + 10'd1) && (pixel_x == 10'd0);
      ref_dly_d = ref_now;
      refr_tick = ref_now & ~ref_dly_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) ref_dly_q <= 1'b0;
      else ref_dly_q <= ref_dly_d;
endmodule

// File: rtl/pong_graphics_anim.sv
// pong_graphics_anim: clk/reset_n plus bus (pixel, buttons in; rgb_pic, hit, miss, miss_cnt out); animated wall/paddle/ball with serve/play/miss FSM
module pong_graphics_anim import pong_pkg::*; #(
   parameter logic [9:0]  H_RES       = H_RES_DEF,
   parameter logic [9:0]  V_RES       = V_RES_DEF,
   parameter logic [9:0]  WALL_X_L    = 10'd32,
   parameter logic [9:0]  WALL_X_R    = 10'd35,
   parameter logic [9:0]  BAR_X_L     = 10'd600,
   parameter logic [9:0]  BAR_X_R     = 10'd603,
   parameter logic [9:0]  BAR_H       = 10'd72,
   parameter logic [9:0]  BAR_V       = 10'd4,
   parameter logic [9:0]  BALL_SIZE   = 10'd8,
   parameter logic [9:0]  BALL_V      = 10'd2,
   parameter logic [9:0]  MISS_FRAMES = 10'd60,
   parameter logic [11:0] WALL_RGB    = WALL_RGB_DEF,
   parameter logic [11:0] BAR_RGB     = BAR_RGB_DEF,
   parameter logic [11:0] BALL_RGB    = BALL_RGB_DEF,
   parameter logic [11:0] BG_RGB      = BG_RGB_DEF
) (
   input logic clk,
   input logic reset_n,
   pong_graphics_anim_if.slave bus
);
   localparam logic [9:0] BAR_Y0 = (V_RES - BAR_H) >> 1;
   localparam logic [9:0] BALL_X0 = (H_RES - BALL_SIZE) >> 1;
   localparam logic [9:0] BALL_Y0 = (V_RES - BALL_SIZE) >> 1;
   state_t state_d, state_q;
   logic [9:0] bar_y_d, bar_y_q, ball_x_d, ball_x_q, ball_y_d, ball_y_q, cnt_d, cnt_q;
   logic dir_x_d, dir_x_q, dir_y_d, dir_y_q, hit_d, hit_q, miss_d, miss_q;
   logic [3:0] miss_cnt_d, miss_cnt_q;
   logic [11:0] rgb_d, rgb_q;
   logic [9:0] x_r, y_b, bar_b;
   logic tick, up_ok, dn_ok, hit_now, dx, dy, in_wall, in_bar, in_ball;
   pong_frame_tick #(.V_RES(V_RES)) u_tick (
      .clk(clk), .reset_n(reset_n), .pixel_x(bus.pixel_x), .pixel_y(bus.pixel_y), .refr_tick(tick)
   );
   always_comb begin
      x_r = ball_x_q + BALL_SIZE - 10'd1;
      y_b = ball_y_q + BALL_SIZE - 10'd1;
      bar_b = bar_y_q + BAR_H - 10'd1;
      up_ok = bus.btn_up & ~bus.btn_dn & (bar_y_q >= BAR_V);
      dn_ok = bus.btn_dn & ~bus.btn_up & (bar_b + BAR_V <= V_RES - 10'd1);
      bar_y_d = ~tick ? bar_y_q : up_ok ? bar_y_q - BAR_V : dn_ok ? bar_y_q + BAR_V : bar_y_q;
      hit_now = (x_r >= BAR_X_L) && (x_r <= BAR_X_R) && (y_b >= bar_y_q) && (ball_y_q <= bar_b);
      dx = hit_now ? 1'b0 : (ball_x_q <= WALL_X_R + BALL_V) ? 1'b1 : dir_x_q;
      dy = (ball_y_q <= BALL_V) ? 1'b1 : (y_b >= V_RES - 10'd1 - BALL_V) ? 1'b0 : dir_y_q;
      state_d = state_q;
      ball_x_d = ball_x_q;
      ball_y_d = ball_y_q;
      dir_x_d = dir_x_q;
      dir_y_d = dir_y_q;
      cnt_d = cnt_q;
      hit_d = 1'b0;
      miss_d = 1'b0;
      miss_cnt_d = miss_cnt_q;
      case (state_q)
         S_IDLE: if (bus.btn_serve) begin
            state_d = S_PLAY;
            dir_x_d = 1'b1;
            dir_y_d = 1'b1;
         end
         S_PLAY: if (tick) begin
            if (x_r > BAR_X_R) begin
               state_d = S_MISS;
               miss_d = 1'b1;
               miss_cnt_d = (miss_cnt_q == 4'hF) ? miss_cnt_q : miss_cnt_q + 4'd1;
            end else begin
               hit_d = hit_now;
               dir_x_d = dx;
               dir_y_d = dy;
               ball_x_d = dx ? ball_x_q + BALL_V : ball_x_q - BALL_V;
               ball_y_d = dy ? ball_y_q + BALL_V : ball_y_q - BALL_V;
            end
         end
         S_MISS: if (tick) begin
            cnt_d = (cnt_q == MISS_FRAMES - 10'd1) ? 10'd0 : cnt_q + 10'd1;
            if (cnt_q == MISS_FRAMES - 10'd1) begin
               state_d = S_IDLE;
               ball_x_d = BALL_X0;
               ball_y_d = BALL_Y0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      in_wall = (bus.pixel_x >= WALL_X_L) && (bus.pixel_x <= WALL_X_R);
      in_bar = (bus.pixel_x >= BAR_X_L) && (bus.pixel_x <= BAR_X_R) && (bus.pixel_y >= bar_y_q) && (bus.pixel_y <= bar_b);
      in_ball = (state_q != S_MISS) && (bus.pixel_x >= ball_x_q) && (bus.pixel_x <= x_r) &&
                (bus.pixel_y >= ball_y_q) && (bus.pixel_y <= y_b);
      rgb_d = ~bus.video_on ? 12'h000 : in_wall ? WALL_RGB : in_bar ? BAR_RGB : in_ball ? BALL_RGB : BG_RGB;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q <= S_IDLE;
         bar_y_q <= BAR_Y0;
         ball_x_q <= BALL_X0;
         ball_y_q <= BALL_Y0;
         dir_x_q <= 1'b1;
         dir_y_q <= 1'b1;
         cnt_q <= 10'd0;
         hit_q <= 1'b0;
         miss_q <= 1'b0;
         miss_cnt_q <= 4'd0;
         rgb_q <= 12'h000;
      end else begin
         state_q <= state_d;
         bar_y_q <= bar_y_d;
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
         dir_x_q <= dir_x_d;
         dir_y_q <= dir_y_d;
         cnt_q <= cnt_d;
         hit_q <= hit_d;
         miss_q <= miss_d;
         miss_cnt_q <= miss_cnt_d;
         rgb_q <= rgb_d;
      end
   assign bus.rgb_pic = rgb_q;
   assign bus.hit = hit_q;
   assign bus.miss = miss_q;
   assign bus.miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_pong_graphics_anim.sv
// tb_pong_graphics_anim: directed checks of drawing, paddle, bounce, hit/miss and reset of pong_graphics_anim
module tb_pong_graphics_anim;
   import pong_pkg::*;
   logic clk = 1'b0;
   logic reset_n;
   int checks = 0;
   int failures = 0;
   int hits = 0;
   int misses = 0;
   logic t_hit, t_miss, t_hit2, t_miss2;
   pong_graphics_anim_if bus ();
   pong_graphics_anim dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic vo,
                        input logic [11:0] exp, input string tag);
      bus.pixel_x = x;
      bus.pixel_y = y;
      bus.video_on = vo;
      @(posedge clk);
      #1;
      check(tag, bus.rgb_pic, exp);
      bus.video_on = 1'b1;
   endtask
   task automatic tick();
      bus.pixel_x = 10'd0;
      bus.pixel_y = 10'd481;
      @(posedge clk);
      #1;
      t_hit = bus.hit;
      t_miss = bus.miss;
      hits += int'(t_hit);
      misses += int'(t_miss);
      bus.pixel_y = 10'd0;
      @(posedge clk);
      #1;
      t_hit2 = bus.hit;
      t_miss2 = bus.miss;
   endtask
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   task automatic serve();
      bus.btn_serve = 1'b1;
      @(posedge clk);
      #1;
      bus.btn_serve = 1'b0;
   endtask
   initial begin
      reset_n = 1'b0;
      bus.video_on = 1'b1;
      bus.pixel_x = 10'd316;
      bus.pixel_y = 10'd236;
      bus.btn_up = 1'b0;
      bus.btn_dn = 1'b0;
      bus.btn_serve = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rgb", bus.rgb_pic, 12'h000);
      check("rst_hit", bus.hit, 0);
      check("rst_miss", bus.miss, 0);
      check("rst_miss_cnt", bus.miss_cnt, 0);
      check("rst_bar_y", dut.bar_y_q, 204);
      check("rst_ball_x", dut.ball_x_q, 316);
      check("rst_ball_y", dut.ball_y_q, 236);
      check("rst_state", dut.state_q, S_IDLE);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("ball_centre_px", bus.rgb_pic, 12'h789);
      probe(10'd33, 10'd10, 1'b1, 12'hABC, "wall_px");
      probe(10'd33, 10'd10, 1'b0, 12'h000, "blank_px");
      probe(10'd0, 10'd0, 1'b1, 12'h6A5, "bg_px");
      probe(10'd600, 10'd204, 1'b1, 12'h0F8, "bar_top_left_px");
      probe(10'd603, 10'd275, 1'b1, 12'h0F8, "bar_bot_right_px");
      probe(10'd603, 10'd276, 1'b1, 12'h6A5, "below_bar_px");
      probe(10'd323, 10'd243, 1'b1, 12'h789, "ball_corner_px");
      probe(10'd324, 10'd243, 1'b1, 12'h6A5, "right_of_ball_px");
      bus.btn_up = 1'b1;
      tick();
      check("bar_up_1", dut.bar_y_q, 200);
      ticks(50);
      check("bar_up_51", dut.bar_y_q, 0);
      ticks(9);
      check("bar_up_clamp", dut.bar_y_q, 0);
      bus.btn_up = 1'b0;
      bus.btn_dn = 1'b1;
      ticks(99);
      check("bar_dn_99", dut.bar_y_q, 396);
      bus.btn_up = 1'b1;
      tick();
      check("bar_both_hold", dut.bar_y_q, 396);
      bus.btn_up = 1'b0;
      bus.btn_dn = 1'b0;
      serve();
      check("serve_state", dut.state_q, S_PLAY);
      hits = 0;
      tick();
      check("ball_x_t1", dut.ball_x_q, 318);
      check("ball_y_t1", dut.ball_y_q, 238);
      ticks(116);
      check("ball_y_t117", dut.ball_y_q, 470);
      check("dir_y_t117", dut.dir_y_q, 1);
      tick();
      check("ball_y_t118", dut.ball_y_q, 468);
      check("dir_y_t118", dut.dir_y_q, 0);
      ticks(21);
      check("no_early_hit", hits, 0);
      tick();
      check("hit_pulse", t_hit, 1);
      check("hit_one_clk", t_hit2, 0);
      check("ball_x_t140", dut.ball_x_q, 592);
      check("miss_cnt_after_hit", bus.miss_cnt, 0);
      tick();
      check("ball_x_t141", dut.ball_x_q, 590);
      check("hit_clear", t_hit, 0);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("bar_after_rst", dut.bar_y_q, 204);
      serve();
      misses = 0;
      ticks(141);
      check("no_early_miss", misses, 0);
      tick();
      check("miss_pulse", t_miss, 1);
      check("miss_one_clk", t_miss2, 0);
      check("miss_cnt_1", bus.miss_cnt, 1);
      check("miss_state", dut.state_q, S_MISS);
      check("miss_ball_x_held", dut.ball_x_q, 598);
      probe(10'd598, 10'd422, 1'b1, 12'h6A5, "ball_hidden_px");
      ticks(59);
      check("miss_state_59", dut.state_q, S_MISS);
      probe(10'd598, 10'd422, 1'b1, 12'h6A5, "ball_hidden_px_59");
      tick();
      check("idle_after_60", dut.state_q, S_IDLE);
      check("recentre_x", dut.ball_x_q, 316);
      check("recentre_y", dut.ball_y_q, 236);
      probe(10'd316, 10'd236, 1'b1, 12'h789, "recentre_px");
      for (int k = 0; k < 14; k++) begin
         serve();
         ticks(202);
      end
      check("miss_cnt_15", bus.miss_cnt, 15);
      serve();
      ticks(142);
      check("miss_pulse_16", t_miss, 1);
      ticks(60);
      check("miss_cnt_sat", bus.miss_cnt, 15);
      serve();
      ticks(145);
      check("pre_rst_state", dut.state_q, S_MISS);
      check("pre_rst_rgb", bus.rgb_pic, 12'h6A5);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_rgb", bus.rgb_pic, 12'h000);
      check("async_miss_cnt", bus.miss_cnt, 0);
      check("async_state", dut.state_q, S_IDLE);
      #10;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_state", dut.state_q, S_IDLE);
      check("post_rst_miss_cnt", bus.miss_cnt, 0);
      bus.btn_dn = 1'b1;
      ticks(60);
      check("bar_dn_clamp", dut.bar_y_q, 408);
      bus.btn_dn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
